// File: rtl/fetch_predictor_pkg.sv
// Shared widths, counter encodings and BTB entry layout for the fetch predictor.
// Prediction is only built when the BTB_PREDICT_EN macro is defined.
package fetch_predictor_pkg;

   localparam int PC_W        = 8;
   localparam int BTB_IDX_W   = 3;
   localparam int BTB_ENTRIES = 1 << BTB_IDX_W;
   localparam int TAG_W       = PC_W - BTB_IDX_W - 2;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } ctr_e;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [PC_W-1:0]  target;
      ctr_e             ctr;
   } btb_entry_t;

   // Saturating 2-bit direction counter step.
   function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
      if (taken) return (c == STRONG_T)  ? STRONG_T  : ctr_e'(c + 2'd1);
      else       return (c == STRONG_NT) ? STRONG_NT : ctr_e'(c - 2'd1);
   endfunction

endpackage

// File: rtl/fetch_predictor_if.sv
// Fetch-stage bus: decode-stage control (master) into the fetch predictor (slave),
// fetch address and IF/ID pipeline register contents back out.
interface fetch_predictor_if #(
   parameter int PC_W = fetch_predictor_pkg::PC_W
);
   logic            stall;
   logic            redirect;
   logic            resolve_valid;
   logic            resolve_taken;
   logic [PC_W-1:0] resolve_pc;
   logic [PC_W-1:0] resolve_target;
   logic [PC_W-1:0] pc_out;
   logic [PC_W-1:0] if_id_pc;
   logic            if_id_pred_taken;
   logic            if_id_valid;

   modport master (
      output stall, redirect, resolve_valid, resolve_taken, resolve_pc, resolve_target,
      input  pc_out, if_id_pc, if_id_pred_taken, if_id_valid
   );

   modport slave (
      input  stall, redirect, resolve_valid, resolve_taken, resolve_pc, resolve_target,
      output pc_out, if_id_pc, if_id_pred_taken, if_id_valid
   );
endinterface

// File: rtl/fetch_predictor_btb_table.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational lookup,
// synchronous update. Only compiled in when BTB_PREDICT_EN is defined.
`ifdef BTB_PREDICT_EN
module btb_table
   import fetch_predictor_pkg::*;
#(
   parameter int PC_W      = fetch_predictor_pkg::PC_W,
   parameter int BTB_IDX_W = fetch_predictor_pkg::BTB_IDX_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [PC_W-1:0] lookup_pc,
   input  logic            upd_en,
   input  logic            upd_taken,
   input  logic [PC_W-1:0] upd_pc,
   input  logic [PC_W-1:0] upd_target,
   output logic            pred_taken,
   output logic [PC_W-1:0] pred_target
);

   btb_entry_t entry_q [BTB_ENTRIES];
   btb_entry_t entry_d [BTB_ENTRIES];

   logic [BTB_IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0]     lk_tag, up_tag;
   btb_entry_t           lk_entry;

   // Instructions are word aligned; the two low PC bits never select anything.
   logic unused_lsbs;
   assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

   assign lk_idx = lookup_pc[BTB_IDX_W+1:2];
   assign lk_tag = lookup_pc[PC_W-1:BTB_IDX_W+2];
   assign up_idx = upd_pc[BTB_IDX_W+1:2];
   assign up_tag = upd_pc[PC_W-1:BTB_IDX_W+2];

   // Lookup reads entry_q, so a same-cycle update to the same index is not seen.
   always_comb begin
      lk_entry    = entry_q[lk_idx];
      pred_taken  = lk_entry.valid && (lk_entry.tag == lk_tag) && lk_entry.ctr[1];
      pred_target = lk_entry.target;
   end

   always_comb begin
      entry_d = entry_q;
      if (upd_en) begin
         if (entry_q[up_idx].valid && (entry_q[up_idx].tag == up_tag)) begin
            entry_d[up_idx].ctr = ctr_update(entry_q[up_idx].ctr, upd_taken);
            if (upd_taken) entry_d[up_idx].target = upd_target;
         end else if (upd_taken) begin
            entry_d[up_idx] = '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: WEAK_T};
         end
      end
   end

   // NOTE: this storage is reset on purpose: every entry must come up invalid with
   // a weak-not-taken counter, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BTB_ENTRIES; i++)
            entry_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WEAK_NT};
      end else begin
         entry_q <= entry_d;
      end
   end

endmodule
`endif

// File: rtl/fetch_predictor.sv
// Fetch stage: PC register, next-PC select and IF/ID register. The BTB predictor is
// present only when BTB_PREDICT_EN is defined; otherwise fetch is always not-taken.
module fetch_predictor
   import fetch_predictor_pkg::*;
#(
   parameter int PC_W      = fetch_predictor_pkg::PC_W,
   parameter int BTB_IDX_W = fetch_predictor_pkg::BTB_IDX_W
) (
   input  logic               clk,
   input  logic               reset,
   fetch_predictor_if.slave   fp
);

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] if_id_pc_q, if_id_pc_d;
   logic            if_id_pred_q, if_id_pred_d;
   logic            if_id_valid_q, if_id_valid_d;

   logic            pred_taken;
   logic [PC_W-1:0] pred_target;

`ifdef BTB_PREDICT_EN
   logic upd_en;
   assign upd_en = fp.resolve_valid & ~fp.stall;

   btb_table #(
      .PC_W      (PC_W),
      .BTB_IDX_W (BTB_IDX_W)
   ) u_btb (
      .clk         (clk),
      .reset       (reset),
      .lookup_pc   (pc_q),
      .upd_en      (upd_en),
      .upd_taken   (fp.resolve_taken),
      .upd_pc      (fp.resolve_pc),
      .upd_target  (fp.resolve_target),
      .pred_taken  (pred_taken),
      .pred_target (pred_target)
   );
`else
   assign pred_taken  = 1'b0;
   assign pred_target = '0;

   logic unused_resolve;
   assign unused_resolve = ^{fp.resolve_valid, fp.resolve_taken, fp.resolve_pc};
`endif

   // NOTE: every output of this block is given a default first so that no path
   // through the if/else chain can infer a latch.
   always_comb begin
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_pred_d  = if_id_pred_q;
      if_id_valid_d = if_id_valid_q;
      if (!fp.stall) begin
         if (fp.redirect) begin
            pc_d          = fp.resolve_target;
            if_id_pc_d    = '0;
            if_id_pred_d  = 1'b0;
            if_id_valid_d = 1'b0;
         end else begin
            pc_d          = pred_taken ? pred_target : pc_q + PC_W'(4);
            if_id_pc_d    = pc_q;
            if_id_pred_d  = pred_taken;
            if_id_valid_d = 1'b1;
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the values computed in the previous combinational phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= '0;
         if_id_pc_q    <= '0;
         if_id_pred_q  <= 1'b0;
         if_id_valid_q <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_pred_q  <= if_id_pred_d;
         if_id_valid_q <= if_id_valid_d;
      end
   end

   assign fp.pc_out           = pc_q;
   assign fp.if_id_pc         = if_id_pc_q;
   assign fp.if_id_pred_taken = if_id_pred_q;
   assign fp.if_id_valid      = if_id_valid_q;

endmodule

// File: tb/tb_fetch_predictor.sv
// Directed bench for fetch_predictor; expectations follow BTB_PREDICT_EN when set.
module tb_fetch_predictor;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fetch_predictor_if fp_if ();

   fetch_predictor dut (
      .clk   (clk),
      .reset (reset),
      .fp    (fp_if.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic stall, input logic redirect, input logic rv,
                        input logic rt, input logic [7:0] rpc, input logic [7:0] rtgt);
      fp_if.stall          = stall;
      fp_if.redirect       = redirect;
      fp_if.resolve_valid  = rv;
      fp_if.resolve_taken  = rt;
      fp_if.resolve_pc     = rpc;
      fp_if.resolve_target = rtgt;
   endtask

   logic btb_on;

   initial begin
`ifdef BTB_PREDICT_EN
      btb_on = 1'b1;
`else
      btb_on = 1'b0;
`endif
      drive(0, 0, 0, 0, 8'h00, 8'h00);

      // Reset state
      step();
      chk("rst_pc",    fp_if.pc_out,           8'h00);
      chk("rst_valid", fp_if.if_id_valid,      8'h00);
      chk("rst_pred",  fp_if.if_id_pred_taken, 8'h00);
      chk("rst_ifpc",  fp_if.if_id_pc,         8'h00);

      // First fetches after reset: 0x00, 0x04, 0x08
      reset = 1'b0;
      step();
      chk("seq_pc1",    fp_if.pc_out,      8'h04);
      chk("seq_valid1", fp_if.if_id_valid, 8'h01);
      chk("seq_ifpc1",  fp_if.if_id_pc,    8'h00);
      step();
      chk("seq_pc2",    fp_if.pc_out,      8'h08);
      chk("seq_ifpc2",  fp_if.if_id_pc,    8'h04);

      // Resolve 0x10 taken to 0x40 (miss -> allocate), then fetch 0x10
      drive(0, 0, 1, 1, 8'h10, 8'h40);
      step();
      chk("alloc_pc", fp_if.pc_out, 8'h0C);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("fetch10_pc", fp_if.pc_out, 8'h10);
      step();
      chk("pred_pc",   fp_if.pc_out,           btb_on ? 8'h40 : 8'h14);
      chk("pred_flag", fp_if.if_id_pred_taken, btb_on ? 8'h01 : 8'h00);
      chk("pred_ifpc", fp_if.if_id_pc,         8'h10);

      // Three not-taken resolves (10 -> 01 -> 00 -> 00 saturated), then one taken (-> 01)
      drive(0, 0, 1, 0, 8'h10, 8'h14);
      step();
      step();
      step();
      chk("nt_pc", fp_if.pc_out, btb_on ? 8'h4C : 8'h20);
      drive(0, 0, 1, 1, 8'h10, 8'h40);
      step();
      drive(0, 1, 0, 0, 8'h00, 8'h10);
      step();
      chk("bub_pc",    fp_if.pc_out,           8'h10);
      chk("bub_valid", fp_if.if_id_valid,      8'h00);
      chk("bub_ifpc",  fp_if.if_id_pc,         8'h00);
      chk("bub_pred",  fp_if.if_id_pred_taken, 8'h00);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("sat_pc",    fp_if.pc_out,           8'h14);
      chk("sat_pred",  fp_if.if_id_pred_taken, 8'h00);
      chk("sat_valid", fp_if.if_id_valid,      8'h01);

      // Taken resolve on a hit retargets the entry to 0x60 (counter 01 -> 10)
      drive(0, 0, 1, 1, 8'h10, 8'h60);
      step();
      drive(0, 1, 0, 0, 8'h00, 8'h10);
      step();
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("retgt_pc",   fp_if.pc_out,           btb_on ? 8'h60 : 8'h14);
      chk("retgt_pred", fp_if.if_id_pred_taken, btb_on ? 8'h01 : 8'h00);

      // Redirect to 0x80: one bubble, then normal fetch
      drive(0, 1, 0, 0, 8'h00, 8'h80);
      step();
      chk("redir_pc",    fp_if.pc_out,      8'h80);
      chk("redir_valid", fp_if.if_id_valid, 8'h00);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("post_pc",    fp_if.pc_out,      8'h84);
      chk("post_valid", fp_if.if_id_valid, 8'h01);
      chk("post_ifpc",  fp_if.if_id_pc,    8'h80);

      // Stall wins over redirect and resolve
      drive(1, 1, 1, 1, 8'h84, 8'h20);
      step();
      chk("stall_pc",    fp_if.pc_out,      8'h84);
      chk("stall_ifpc",  fp_if.if_id_pc,    8'h80);
      chk("stall_valid", fp_if.if_id_valid, 8'h01);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("unstall_pc", fp_if.pc_out, 8'h88);
      drive(0, 1, 0, 0, 8'h00, 8'h84);
      step();
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("stall_noupd_pc", fp_if.pc_out, 8'h88);

      // PC wraps modulo 256
      drive(0, 1, 0, 0, 8'h00, 8'hFC);
      step();
      chk("wrap_pre", fp_if.pc_out, 8'hFC);
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("wrap_pc",   fp_if.pc_out,   8'h00);
      chk("wrap_ifpc", fp_if.if_id_pc, 8'hFC);

      // Mid-operation reset overrides redirect and clears the BTB
      reset = 1'b1;
      drive(0, 1, 1, 1, 8'h40, 8'h40);
      step();
      chk("mrst_pc",    fp_if.pc_out,      8'h00);
      chk("mrst_valid", fp_if.if_id_valid, 8'h00);
      chk("mrst_ifpc",  fp_if.if_id_pc,    8'h00);
      reset = 1'b0;
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("mrst_first", fp_if.pc_out, 8'h04);
      drive(0, 1, 0, 0, 8'h00, 8'h10);
      step();
      drive(0, 0, 0, 0, 8'h00, 8'h00);
      step();
      chk("mrst_btb_pc",   fp_if.pc_out,           8'h14);
      chk("mrst_btb_pred", fp_if.if_id_pred_taken, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_predictor.md
FETCH_PREDICTOR -- requirements
Module: fetch_predictor

Interface
REQ-001 Parameter PC_W, default 8: PC and target width in bits.
REQ-002 Parameter BTB_IDX_W, default 3: BTB index width, giving 2^BTB_IDX_W = 8 entries.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hazard hold; freezes PC, IF/ID outputs and BTB.
REQ-006 redirect  input  1  mispredict flag from decode-stage branch control (branch_wrong).
REQ-007 resolve_valid  input  1  decode stage holds a resolved control-flow instruction this cycle.
REQ-008 resolve_taken  input  1  actual direction of the resolved instruction.
REQ-009 resolve_pc  input  PC_W  PC of the resolved instruction (IF/ID PC).
REQ-010 resolve_target  input  PC_W  correct next PC of the resolved instruction (pc_branch).
REQ-011 pc_out  output  PC_W  current fetch address to instruction memory.
REQ-012 if_id_pc  output  PC_W  registered PC of the instruction in IF/ID.
REQ-013 if_id_pred_taken  output  1  registered prediction for that instruction (branch_indicator source).
REQ-014 if_id_valid  output  1  0 = IF/ID holds a bubble.

Function
REQ-015 BTB: 8 direct-mapped entries; index = pc[BTB_IDX_W+1:2]; tag = pc[PC_W-1:BTB_IDX_W+2]; fields valid, tag, target (PC_W), 2-bit counter.
REQ-016 Lookup is combinational on pc_out; hit = valid and tag match; predict taken = hit and counter[1].
REQ-017 next_pc priority: stall -> hold pc_out; else redirect -> resolve_target; else predict taken -> BTB target; else pc_out + 4.
REQ-018 PC arithmetic is modulo 2^PC_W; 0xFC + 4 = 0x00, no carry-out.
REQ-019 When not stalled, IF/ID captures if_id_pc <= pc_out, if_id_pred_taken <= prediction, if_id_valid <= 1, one cycle latency.
REQ-020 On redirect (not stalled), IF/ID loads a bubble: if_id_valid = 0, if_id_pred_taken = 0, if_id_pc = 0.
REQ-021 stall and redirect together: stall wins; redirect and resolve are ignored that cycle.
REQ-022 Update only when resolve_valid and not stall, using resolve_pc index/tag.
REQ-023 Update on hit: counter +1 if taken, -1 if not; saturate at 2'b11 and 2'b00; target <= resolve_target if taken.
REQ-024 Update on miss: if taken, allocate (valid = 1, tag, target, counter = 2'b10); if not taken, no change.
REQ-025 Same-cycle lookup and update on one index: lookup uses pre-update contents (read-before-write).

Reset
REQ-026 On reset: pc_out = 0x00; if_id_pc = 0, if_id_pred_taken = 0, if_id_valid = 0; all BTB valid = 0, counters = 2'b01.
REQ-027 Reset overrides stall, redirect and update; asserting it mid-operation discards in-flight state.
REQ-028 First fetch after reset deassertion is address 0x00.

Configuration
REQ-029 Macro BTB_PREDICT_EN defined: BTB and counters are present, behaviour per REQ-015 to REQ-025.
REQ-030 Macro undefined: no BTB storage; prediction always not-taken; next_pc = redirect ? resolve_target : pc_out + 4; if_id_pred_taken is constant 0.

Structure
REQ-031 A shared package holds PC_W, BTB_IDX_W, the derived tag width, the counter encodings (STRONG_NT = 00, WEAK_NT = 01, WEAK_T = 10, STRONG_T = 11) and the BTB entry struct typedef.
REQ-032 Sub-module btb_table contains the storage, combinational lookup and synchronous update; fetch_predictor contains the PC register, next-PC mux and IF/ID register.

Verification
REQ-033 Reset, then 3 unstalled cycles -> pc_out sequence 0x00, 0x04, 0x08; if_id_valid = 1 from cycle 2.
REQ-034 Resolve pc 0x10 taken to 0x40 (miss), then fetch 0x10 -> BTB allocates counter 10; next fetch of 0x10 predicts taken, pc_out becomes 0x40 and if_id_pred_taken = 1.
REQ-035 Entry at 0x10 with counter 10 receives two not-taken resolves -> counter 00; next fetch of 0x10 gives pc_out + 4 = 0x14.
REQ-036 redirect = 1 with resolve_target = 0x80 -> next pc_out = 0x80 and if_id_valid = 0 for one cycle; stall together with redirect -> pc_out and IF/ID unchanged.
REQ-037 pc_out = 0xFC, no hit -> next pc_out = 0x00.
REQ-038 With BTB_PREDICT_EN undefined, repeat REQ-034 -> no redirect to 0x40 via prediction; if_id_pred_taken stays 0.
